updown_counter_mod: RTL and testbench

- Parametrised successor to the team's fixed 5-bit up/down counter.
- Width and modulus are set by parameters. Adds synchronous clear, parallel load, wrap/saturate mode and a registered wrap pulse.
- Keeps the terminal flags up_out (count at maximum) and down_out (count at zero) so existing callers can chain it into prescalers and timeout logic.

---
 rtl/updown_counter_mod.sv | 76 +++++++
 tb/tb_updown_counter_mod.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with clear, clamped parallel load, wrap/saturate
// mode, terminal-count flags and a registered wrap pulse.
module updown_counter_mod #(
  parameter int WIDTH    = 5,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             count_type,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             up_out,
  output logic             down_out,
  output logic             wrap_out
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_CNT};

  logic [WIDTH:0]   inc_val;
  logic [WIDTH:0]   dec_val;
  logic             at_top;
  logic             at_bottom;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // One extra bit on both paths exposes the carry past MAX_VAL and the borrow below zero.
  assign inc_val   = {1'b0, count_out} + (WIDTH+1)'(1);
  assign dec_val   = {1'b0, count_out} - (WIDTH+1)'(1);
  assign at_top    = inc_val > MAX_EXT;
  assign at_bottom = dec_val[WIDTH];

  assign up_out   = (count_out == MAX_CNT);
  assign down_out = (count_out == '0);

  always_comb begin
    count_nxt = count_out;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    end else if (en) begin
      if (!count_type) begin
        if (at_top) begin
          wrap_nxt  = 1'b1;
          count_nxt = SATURATE ? MAX_CNT : '0;
        end else begin
          count_nxt = inc_val[WIDTH-1:0];
        end
      end else begin
        if (at_bottom) begin
          wrap_nxt  = 1'b1;
          count_nxt = SATURATE ? '0 : MAX_CNT;
        end else begin
          count_nxt = dec_val[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
      wrap_out  <= 1'b0;
    end else begin
      count_out <= count_nxt;
      wrap_out  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: four configurations share one stimulus stream;
// expected values come from a vector table and a behavioural model via a scoreboard queue.
module tb_updown_counter_mod;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dn;
  logic       clr;
  logic       load;
  logic [4:0] load_val;

  logic [4:0] cnt_def, cnt_w9, cnt_s9;
  logic [1:0] cnt_t2;
  logic       up_def, up_w9, up_s9, up_t2;
  logic       dn_def, dn_w9, dn_s9, dn_t2;
  logic       wr_def, wr_w9, wr_s9, wr_t2;

  updown_counter_mod u_def (
    .clk(clk), .rst(rst), .en(en), .count_type(dn), .clr(clr), .load(load),
    .load_val(load_val), .count_out(cnt_def), .up_out(up_def), .down_out(dn_def),
    .wrap_out(wr_def));

  updown_counter_mod #(.WIDTH(5), .MAX_VAL(9), .SATURATE(1'b0)) u_w9 (
    .clk(clk), .rst(rst), .en(en), .count_type(dn), .clr(clr), .load(load),
    .load_val(load_val), .count_out(cnt_w9), .up_out(up_w9), .down_out(dn_w9),
    .wrap_out(wr_w9));

  updown_counter_mod #(.WIDTH(5), .MAX_VAL(9), .SATURATE(1'b1)) u_s9 (
    .clk(clk), .rst(rst), .en(en), .count_type(dn), .clr(clr), .load(load),
    .load_val(load_val), .count_out(cnt_s9), .up_out(up_s9), .down_out(dn_s9),
    .wrap_out(wr_s9));

  updown_counter_mod #(.WIDTH(2), .MAX_VAL(1), .SATURATE(1'b0)) u_t2 (
    .clk(clk), .rst(rst), .en(en), .count_type(dn), .clr(clr), .load(load),
    .load_val(load_val[1:0]), .count_out(cnt_t2), .up_out(up_t2), .down_out(dn_t2),
    .wrap_out(wr_t2));

  localparam int MAXS [4] = '{31, 9, 9, 1};
  localparam bit SATS [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [4:0] act_cnt [4];
  logic [3:0] act_up, act_dn, act_wr;

  always_comb begin
    act_cnt[0] = cnt_def;
    act_cnt[1] = cnt_w9;
    act_cnt[2] = cnt_s9;
    act_cnt[3] = {3'b000, cnt_t2};
    act_up = {up_t2, up_s9, up_w9, up_def};
    act_dn = {dn_t2, dn_s9, dn_w9, dn_def};
    act_wr = {wr_t2, wr_s9, wr_w9, wr_def};
  end

  typedef struct packed {
    logic       clr;
    logic       load;
    logic       en;
    logic       dn;
    logic [4:0] lv;
    logic [4:0] w_cnt;
    logic       w_wrap;
    logic [4:0] s_cnt;
    logic       s_wrap;
  } vec_t;

  typedef struct packed {
    logic [3:0][4:0] cnt;
    logic [3:0]      wrap;
    logic [7:0]      tag;
  } exp_t;

  vec_t       vecs [$];
  exp_t       sb [$];
  logic [4:0] m_cnt [4];
  int         checks = 0;
  int         errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic vec_t row(input logic c, l, e, d, input logic [4:0] lv,
                               input logic [4:0] wc, input logic ww,
                               input logic [4:0] sc, input logic sw);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.dn = d; v.lv = lv;
    v.w_cnt = wc; v.w_wrap = ww; v.s_cnt = sc; v.s_wrap = sw;
    return v;
  endfunction

  // Returns {wrap, next_count} for one edge of a counter with range 0..mx.
  function automatic logic [5:0] model(input logic [4:0] c, input int mx, input bit sat,
                                       input logic cl, ld, e, d, input logic [4:0] lv);
    logic [4:0] n;
    logic       w;
    n = c;
    w = 1'b0;
    if (cl) n = 5'd0;
    else if (ld) n = (int'(lv) > mx) ? 5'(mx) : lv;
    else if (e) begin
      if (!d) begin
        if (int'(c) == mx) begin w = 1'b1; n = sat ? 5'(mx) : 5'd0; end
        else n = c + 5'd1;
      end else begin
        if (c == 5'd0) begin w = 1'b1; n = sat ? 5'd0 : 5'(mx); end
        else n = c - 5'd1;
      end
    end
    return {w, n};
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic compare_pop();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    x = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("count[%0d]", x.tag), i, int'(act_cnt[i]), int'(x.cnt[i]));
      check($sformatf("wrap[%0d]", x.tag), i, int'(act_wr[i]), int'(x.wrap[i]));
      check($sformatf("up[%0d]", x.tag), i, int'(act_up[i]), int'(x.cnt[i]) == MAXS[i]);
      check($sformatf("down[%0d]", x.tag), i, int'(act_dn[i]), int'(x.cnt[i]) == 0);
    end
  endtask

  // Drives one cycle, pushes expectations, then compares just after the edge.
  task automatic drive(input logic c, l, e, d, input logic [4:0] lv, input bit has_tbl,
                       input logic [4:0] wc, input logic ww, input logic [4:0] sc,
                       input logic sw, input logic [7:0] tag);
    exp_t       x;
    logic [5:0] r;
    @(negedge clk);
    clr = c; load = l; en = e; dn = d; load_val = lv;
    for (int i = 0; i < 4; i++) begin
      r = model(m_cnt[i], MAXS[i], SATS[i], c, l, e, d, (i == 3) ? (lv & 5'd3) : lv);
      m_cnt[i]  = r[4:0];
      x.cnt[i]  = r[4:0];
      x.wrap[i] = r[5];
    end
    if (has_tbl) begin
      x.cnt[1] = wc; x.wrap[1] = ww;
      x.cnt[2] = sc; x.wrap[2] = sw;
      m_cnt[1] = wc; m_cnt[2] = sc;
    end
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic check_reset_state(input string nm);
    for (int i = 0; i < 4; i++) begin
      check({nm, "_cnt"}, i, int'(act_cnt[i]), 0);
      check({nm, "_wrap"}, i, int'(act_wr[i]), 0);
      check({nm, "_up"}, i, int'(act_up[i]), 0);
      check({nm, "_down"}, i, int'(act_dn[i]), 1);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = 5'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 5'd0;

    // up 12 cycles from 0
    for (int k = 1; k <= 9; k++)
      vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'(k), 0, 5'(k), 0));
    vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'd0, 1, 5'd9, 1));
    vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'd1, 0, 5'd9, 1));
    vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'd2, 0, 5'd9, 1));
    // down from 0, then immediate direction change
    vecs.push_back(row(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0));
    vecs.push_back(row(0, 0, 1, 1, 5'd0, 5'd9, 1, 5'd0, 1));
    vecs.push_back(row(0, 0, 1, 1, 5'd0, 5'd8, 0, 5'd0, 1));
    vecs.push_back(row(0, 0, 1, 1, 5'd0, 5'd7, 0, 5'd0, 1));
    vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'd8, 0, 5'd1, 0));
    // saturate at top from 8
    vecs.push_back(row(0, 1, 0, 0, 5'd8, 5'd8, 0, 5'd8, 0));
    vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'd9, 0, 5'd9, 0));
    vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'd0, 1, 5'd9, 1));
    vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'd1, 0, 5'd9, 1));
    // priority and clamp
    vecs.push_back(row(0, 1, 0, 0, 5'd20, 5'd9, 0, 5'd9, 0));
    vecs.push_back(row(0, 1, 0, 0, 5'd10, 5'd9, 0, 5'd9, 0));
    vecs.push_back(row(1, 1, 0, 0, 5'd5, 5'd0, 0, 5'd0, 0));
    vecs.push_back(row(0, 1, 0, 0, 5'd9, 5'd9, 0, 5'd9, 0));
    vecs.push_back(row(0, 1, 1, 0, 5'd4, 5'd4, 0, 5'd4, 0));
    vecs.push_back(row(1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0));
    vecs.push_back(row(0, 1, 0, 0, 5'd4, 5'd4, 0, 5'd4, 0));
    // hold with direction toggling, then count
    for (int k = 0; k < 5; k++)
      vecs.push_back(row(0, 0, 0, k[0], 5'd0, 5'd4, 0, 5'd4, 0));
    vecs.push_back(row(0, 0, 1, 0, 5'd0, 5'd5, 0, 5'd5, 0));

    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      drive(vecs[k].clr, vecs[k].load, vecs[k].en, vecs[k].dn, vecs[k].lv, 1'b1,
            vecs[k].w_cnt, vecs[k].w_wrap, vecs[k].s_cnt, vecs[k].s_wrap, 8'(k));

    // count on, then asynchronous reset mid-cycle with a load pending
    drive(0, 0, 1, 0, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd100);
    drive(0, 0, 1, 0, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd101);
    @(negedge clk);
    load = 1'b1; load_val = 5'd7; en = 1'b1; dn = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    @(posedge clk);
    #1 check_reset_state("rst_held");
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 5'd0;

    // first edges after reset, then alternating direction for back-to-back wraps at MAX_VAL=1
    drive(0, 0, 1, 0, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd110);
    drive(0, 0, 1, 1, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd111);
    drive(0, 0, 1, 1, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd112);
    drive(0, 0, 1, 0, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd113);
    drive(0, 0, 1, 1, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd114);
    drive(0, 0, 0, 0, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd115);
    drive(0, 1, 0, 0, 5'd31, 1'b0, 5'd0, 0, 5'd0, 0, 8'd116);
    drive(0, 0, 1, 0, 5'd0, 1'b0, 5'd0, 0, 5'd0, 0, 8'd117);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
